// File: rtl/agente_driver_monitor.sv
// agente_driver_monitor
//   Stimulus/observation front-end for the ROWS x COLUMS mesh router.
//   Driver side: injection requests are packed into router packets and queued
//   in one FIFO per boundary terminal, whose heads are presented to the mesh.
//   Monitor side: packets delivered by the mesh are popped one per cycle
//   (round-robin over terminals) and reported on a single stream, with a flag
//   when the destination does not match the receiving terminal.
//
// Ports
//   clk, reset         clock (rising edge), async active-low reset
//   req_*              injection request handshake and packet fields
//   pndng_i_in         per-terminal "FIFO non-empty" toward the mesh
//   data_out_i_in      per-terminal FIFO head (zero when empty)
//   popin              mesh consumed the head of terminal i
//   pndng, data_out    mesh has a packet for terminal i / that packet
//   pop                one-cycle pop of mesh output i
//   rpt_*              report stream (valid, terminal, packet, misroute)
module agente_driver_monitor #(
  parameter int ROWS      = 4,
  parameter int COLUMS    = 4,
  parameter int pckg_sz   = 40,
  parameter int fifo_size = 4,
  localparam int Drivers  = 2*ROWS + 2*COLUMS,
  localparam int PW       = pckg_sz - 17,
  localparam int SW       = $clog2(Drivers)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [SW-1:0]                req_source,
  input  logic [3:0]                   req_row,
  input  logic [3:0]                   req_col,
  input  logic                         req_mode,
  input  logic [PW-1:0]                req_payload,
  output logic [Drivers-1:0]           pndng_i_in,
  output logic [Drivers*pckg_sz-1:0]   data_out_i_in,
  input  logic [Drivers-1:0]           popin,
  input  logic [Drivers-1:0]           pndng,
  input  logic [Drivers*pckg_sz-1:0]   data_out,
  output logic [Drivers-1:0]           pop,
  output logic                         rpt_valid,
  output logic [SW-1:0]                rpt_terminal,
  output logic [pckg_sz-1:0]           rpt_data,
  output logic                         rpt_misroute
);

  localparam int AW = (fifo_size > 1) ? $clog2(fifo_size) : 1;
  localparam int CW = $clog2(fifo_size + 1);

  // Mesh coordinates {row, col} of boundary terminal i.
  function automatic logic [7:0] coord(input int i);
    int r;
    int c;
    if (i < COLUMS) begin
      r = 0;
      c = i + 1;
    end else if (i < COLUMS + ROWS) begin
      r = i - COLUMS + 1;
      c = 0;
    end else if (i < 2*COLUMS + ROWS) begin
      r = ROWS + 1;
      c = i - COLUMS - ROWS + 1;
    end else begin
      r = i - 2*COLUMS - ROWS + 1;
      c = COLUMS + 1;
    end
    return {r[3:0], c[3:0]};
  endfunction

  // ---------------- driver side ----------------
  logic [pckg_sz-1:0] mem    [Drivers][fifo_size];
  logic [AW-1:0]      wr_ptr [Drivers];
  logic [AW-1:0]      rd_ptr [Drivers];
  logic [CW-1:0]      count  [Drivers];

  logic [Drivers-1:0] full;
  logic [Drivers-1:0] do_push;
  logic [Drivers-1:0] do_pop;
  logic               src_ok;
  logic [7:0]         src_coord;
  logic [3:0]         pk_row;
  logic [3:0]         pk_col;
  logic [pckg_sz-1:0] pkt;

  always_comb begin
    for (int i = 0; i < Drivers; i++) begin
      full[i]       = (count[i] == CW'(fifo_size));
      pndng_i_in[i] = (count[i] != '0);
      data_out_i_in[i*pckg_sz +: pckg_sz] = (count[i] != '0) ? mem[i][rd_ptr[i]] : '0;
    end
  end

  assign src_ok    = (int'(req_source) < Drivers);
  assign req_ready = src_ok && !full[req_source];
  assign src_coord = coord(int'(req_source));

  // A request aimed at the injecting terminal itself is redirected by
  // swapping row and column, so it still crosses the mesh.
  always_comb begin
    pk_row = req_row;
    pk_col = req_col;
    if ({req_row, req_col} == src_coord) begin
      pk_row = req_col;
      pk_col = req_row;
    end
    pkt = {8'h00, pk_row, pk_col, req_mode, req_payload};
  end

  always_comb begin
    for (int i = 0; i < Drivers; i++) begin
      do_push[i] = req_valid && req_ready && (int'(req_source) == i);
      do_pop[i]  = popin[i] && (count[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Drivers; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < Drivers; i++) begin
        if (do_push[i])
          wr_ptr[i] <= (wr_ptr[i] == AW'(fifo_size-1)) ? '0 : wr_ptr[i] + 1'b1;
        if (do_pop[i])
          rd_ptr[i] <= (rd_ptr[i] == AW'(fifo_size-1)) ? '0 : rd_ptr[i] + 1'b1;
        if (do_push[i] && !do_pop[i])
          count[i] <= count[i] + 1'b1;
        else if (!do_push[i] && do_pop[i])
          count[i] <= count[i] - 1'b1;
      end
    end
  end

  // Storage needs no reset: heads are masked to zero while a FIFO is empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < Drivers; i++)
      if (do_push[i])
        mem[i][wr_ptr[i]] <= pkt;
  end

  // ---------------- monitor side ----------------
  logic [SW-1:0]      rr_ptr;
  logic [Drivers-1:0] eligible;
  logic               found;
  logic [SW-1:0]      grant;
  logic [pckg_sz-1:0] grant_data;
  logic               grant_mis;

  // A terminal popped last cycle is skipped while the mesh drops pndng.
  assign eligible = pndng & ~pop;

  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 1; k <= Drivers; k++) begin
      if (!found && eligible[(int'(rr_ptr) + k) % Drivers]) begin
        found = 1'b1;
        grant = SW'((int'(rr_ptr) + k) % Drivers);
      end
    end
  end

  assign grant_data = data_out[int'(grant)*pckg_sz +: pckg_sz];
  assign grant_mis  = (grant_data[pckg_sz-9 -: 8] != coord(int'(grant)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop          <= '0;
      rpt_valid    <= 1'b0;
      rpt_terminal <= '0;
      rpt_data     <= '0;
      rpt_misroute <= 1'b0;
      rr_ptr       <= SW'(Drivers-1);
    end else begin
      pop       <= '0;
      rpt_valid <= found;
      if (found) begin
        pop[grant]   <= 1'b1;
        rpt_terminal <= grant;
        rpt_data     <= grant_data;
        rpt_misroute <= grant_mis;
        rr_ptr       <= grant;
      end
    end
  end

endmodule

// File: tb/tb_agente_driver_monitor.sv
module tb_agente_driver_monitor;

  localparam int Drivers = 16;
  localparam int PS = 40;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req_valid;
  logic                 req_ready;
  logic [3:0]           req_source;
  logic [3:0]           req_row;
  logic [3:0]           req_col;
  logic                 req_mode;
  logic [22:0]          req_payload;
  logic [Drivers-1:0]   pndng_i_in;
  logic [Drivers*PS-1:0] data_out_i_in;
  logic [Drivers-1:0]   popin;
  logic [Drivers-1:0]   pndng;
  logic [Drivers*PS-1:0] data_out;
  logic [Drivers-1:0]   pop;
  logic                 rpt_valid;
  logic [3:0]           rpt_terminal;
  logic [PS-1:0]        rpt_data;
  logic                 rpt_misroute;

  int n_checks = 0;
  int n_errors = 0;

  agente_driver_monitor dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_source(req_source),
    .req_row(req_row), .req_col(req_col), .req_mode(req_mode), .req_payload(req_payload),
    .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in), .popin(popin),
    .pndng(pndng), .data_out(data_out), .pop(pop),
    .rpt_valid(rpt_valid), .rpt_terminal(rpt_terminal), .rpt_data(rpt_data),
    .rpt_misroute(rpt_misroute)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PS-1:0] head(input int i);
    return data_out_i_in[i*PS +: PS];
  endfunction

  // Drive one request for a cycle; expected ready checked before the edge.
  task automatic push(input int src, input int row, input int col, input bit mode,
                      input int payload, input bit exp_ready, input string tag);
    req_valid   = 1'b1;
    req_source  = 4'(src);
    req_row     = 4'(row);
    req_col     = 4'(col);
    req_mode    = mode;
    req_payload = 23'(payload);
    #1 check(tag, 64'(req_ready), 64'(exp_ready));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic pop_head(input int i);
    popin[i] = 1'b1;
    @(negedge clk);
    popin = '0;
  endtask

  int seq_t [3] = '{0, 7, 15};
  bit seq_m [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_source = '0; req_row = '0; req_col = '0;
    req_mode = 1'b0; req_payload = '0;
    popin = '0; pndng = '0; data_out = '0;

    // reset held 5 cycles
    repeat (5) @(negedge clk);
    check("rst_pndng_i_in", 64'(pndng_i_in), 64'h0);
    check("rst_data_or", 64'(|data_out_i_in), 64'h0);
    check("rst_pop", 64'(pop), 64'h0);
    check("rst_rpt_valid", 64'(rpt_valid), 64'h0);
    check("rst_rpt_data", 64'(rpt_data), 64'h0);
    check("rst_rpt_term", 64'(rpt_terminal), 64'h0);
    check("rst_rpt_mis", 64'(rpt_misroute), 64'h0);
    reset = 1'b1;
    @(negedge clk);
    for (int s = 0; s < Drivers; s++) begin
      req_source = 4'(s);
      #1 check($sformatf("ready_src%0d", s), 64'(req_ready), 64'h1);
    end
    @(negedge clk);

    // basic injection on terminal 0
    push(0, 2, 3, 1'b1, 'h15, 1'b1, "inj0_ready");
    check("inj0_pndng", 64'(pndng_i_in[0]), 64'h1);
    check("inj0_head", 64'(head(0)), 64'h0023800015);
    pop_head(0);
    check("inj0_popped", 64'(pndng_i_in[0]), 64'h0);
    check("inj0_head_empty", 64'(head(0)), 64'h0);

    // self-addressed request from terminal 4 (1,0) gets row/col swapped
    push(4, 1, 0, 1'b0, 'hABC, 1'b1, "inj4_ready");
    check("inj4_swap", 64'(head(4)), 64'h0001000ABC);

    // fill terminal 3 (target (1,2))
    for (int p = 1; p <= 4; p++)
      push(3, 1, 2, 1'b0, p, 1'b1, $sformatf("fill3_ready%0d", p));
    check("fill3_head", 64'(head(3)), 64'h0012000001);
    // full: push refused, pop still happens
    popin[3] = 1'b1;
    push(3, 1, 2, 1'b0, 5, 1'b0, "full3_ready");
    popin = '0;
    check("full3_pop_head", 64'(head(3)), 64'h0012000002);
    // not full: push and pop together
    popin[3] = 1'b1;
    push(3, 1, 2, 1'b0, 5, 1'b1, "pp3_ready");
    popin = '0;
    check("pp3_head", 64'(head(3)), 64'h0012000003);
    push(3, 1, 2, 1'b0, 6, 1'b1, "refill3_ready");
    push(3, 1, 2, 1'b0, 7, 1'b0, "refull3_ready");
    for (int p = 3; p <= 6; p++) begin
      check($sformatf("order3_%0d", p), 64'(head(3)), 64'h0012000000 | 64'(p));
      pop_head(3);
    end
    check("drain3_pndng", 64'(pndng_i_in[3]), 64'h0);

    // monitor: terminal 5 (2,0), correct destination
    data_out[5*PS +: PS] = 40'h0020000055;
    pndng[5] = 1'b1;
    @(negedge clk);
    pndng[5] = 1'b0;
    check("mon5_pop", 64'(pop), 64'h0020);
    check("mon5_valid", 64'(rpt_valid), 64'h1);
    check("mon5_term", 64'(rpt_terminal), 64'd5);
    check("mon5_data", 64'(rpt_data), 64'h0020000055);
    check("mon5_mis", 64'(rpt_misroute), 64'h0);
    @(negedge clk);
    check("mon5_pop_once", 64'(pop), 64'h0);
    check("mon5_valid_once", 64'(rpt_valid), 64'h0);
    // misrouted packet on terminal 5
    data_out[5*PS +: PS] = 40'h0033000066;
    pndng[5] = 1'b1;
    @(negedge clk);
    pndng[5] = 1'b0;
    check("mis5_term", 64'(rpt_terminal), 64'd5);
    check("mis5_mis", 64'(rpt_misroute), 64'h1);
    @(negedge clk);

    // reset mid-operation: terminal 4 still queued, arbiter pointer restored
    check("pre_rst_pndng4", 64'(pndng_i_in[4]), 64'h1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_pndng", 64'(pndng_i_in), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_head4", 64'(head(4)), 64'h0);

    // round-robin among 0 (0,1), 7 (4,0), 15 (4,5)
    data_out[0*PS +: PS]  = 40'h0001000011;
    data_out[7*PS +: PS]  = 40'h0011000077;
    data_out[15*PS +: PS] = 40'h00450000FF;
    pndng = 16'h8081;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check($sformatf("rr%0d_pop", j), 64'(pop), 64'(16'h1 << seq_t[j%3]));
      check($sformatf("rr%0d_term", j), 64'(rpt_terminal), 64'(seq_t[j%3]));
      check($sformatf("rr%0d_mis", j), 64'(rpt_misroute), 64'(seq_m[j%3]));
      check($sformatf("rr%0d_valid", j), 64'(rpt_valid), 64'h1);
    end
    pndng = '0;
    @(negedge clk);
    check("rr_idle_pop", 64'(pop), 64'h0);
    check("rr_idle_valid", 64'(rpt_valid), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
